sprite_char_ctrl: RTL

- Parametrised character controller for player and enemy sprites; successor to the fixed 16x16 player block.
- Latches a user or AI command, applies movement with per-direction collision, a speed divider and screen clamping.
- Scans the active sprite (walk or extended attack) out of an external sprite-sheet ROM into the VGA pixel stream.
- Sits between the game control FSM, collision_detector, sprite ROM and VGA write mux.

---
 rtl/sprite_char_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_char_ctrl.sv
// Sprite character controller: command latch, stepped movement with collision/clamp,
// and sprite-sheet scan-out. Optional `WALK_ANIM_EN adds a two-frame walk cycle.
module sprite_char_ctrl #(
    parameter int                     X_W       = 9,
    parameter int                     Y_W       = 8,
    parameter int                     SPR_W     = 16,
    parameter int                     SPR_H     = 16,
    parameter int                     SHEET_W   = 64,
    parameter int                     ADDR_W    = 12,
    parameter int                     COLOUR_W  = 6,
    parameter logic [COLOUR_W-1:0]    TRANSP    = {COLOUR_W{1'b1}},
    parameter int                     SPEED_DIV = 16,
    parameter int                     X_INIT    = 1,
    parameter int                     Y_INIT    = 96,
    parameter int                     X_MIN     = 0,
    parameter int                     X_MAX     = 303,
    parameter int                     Y_MIN     = 0,
    parameter int                     Y_MAX     = 223
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_attack,
    input  logic                cmd_up,
    input  logic                cmd_down,
    input  logic                cmd_left,
    input  logic                cmd_right,
    input  logic                init,
    input  logic                reg_action,
    input  logic                apply_action,
    input  logic [3:0]          collision,
    input  logic                draw_start,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x_pos,
    output logic [Y_W-1:0]      y_pos,
    output logic [1:0]          facing,
    output logic [2:0]          action,
    output logic [X_W-1:0]      x_draw,
    output logic [Y_W-1:0]      y_draw,
    output logic [COLOUR_W-1:0] colour,
    output logic                vga_write,
    output logic                busy,
    output logic                draw_done
);
    localparam int CW       = $clog2(2*SPR_W);
    localparam int RW       = $clog2(2*SPR_H);
    localparam int SW       = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int SHEET_SH = $clog2(SHEET_W);
    localparam int SPR_W_SH = $clog2(SPR_W);

    localparam logic [2:0] ACT_NONE = 3'd0, ACT_ATTACK = 3'd1, ACT_UP = 3'd2;
    localparam logic [2:0] ACT_DOWN = 3'd3, ACT_LEFT = 3'd4, ACT_RIGHT = 3'd5;
    localparam logic [1:0] FACE_DOWN = 2'd0, FACE_LEFT = 2'd1, FACE_UP = 2'd2, FACE_RIGHT = 2'd3;
    localparam logic [0:0] ST_IDLE = 1'b0, ST_SCAN = 1'b1;

    logic [0:0]          state;
    logic [SW-1:0]       spd_cnt;
    logic                frame;
    logic [2:0]          nxt_action;
    logic [X_W-1:0]      nxt_x;
    logic [Y_W-1:0]      nxt_y;
    logic [1:0]          nxt_face;
    logic                moved;
    logic                accept_reg;
    logic                accept_apply;
    logic                step;
    logic [CW-1:0]       col, col_last, g_col_last;
    logic [RW-1:0]       row, row_last, g_row_last;
    logic [ADDR_W-1:0]   org_x, org_y, g_ox, g_oy;
    logic [X_W-1:0]      base_x, g_bx;
    logic [Y_W-1:0]      base_y, g_by;
    logic                pix_valid, pix_last, a_last;

    // draw_start is a one-cycle request, taken only while busy is low; busy then
    // stays high until the cycle carrying the last pixel and draw_done.
    assign busy         = (state == ST_SCAN) || pix_valid;
    assign accept_reg   = reg_action && !busy && !init;
    assign accept_apply = apply_action && !busy && !init && !reg_action;
    assign step         = accept_apply && (spd_cnt == '0);

    always_comb begin
        if (cmd_attack)     nxt_action = ACT_ATTACK;
        else if (cmd_up)    nxt_action = ACT_UP;
        else if (cmd_down)  nxt_action = ACT_DOWN;
        else if (cmd_left)  nxt_action = ACT_LEFT;
        else if (cmd_right) nxt_action = ACT_RIGHT;
        else                nxt_action = ACT_NONE;
    end

    // Facing follows the direction even when the move is blocked.
    always_comb begin
        nxt_x    = x_pos;
        nxt_y    = y_pos;
        nxt_face = facing;
        moved    = 1'b0;
        case (action)
            ACT_UP: begin
                nxt_face = FACE_UP;
                if (!collision[0] && y_pos > Y_W'(Y_MIN)) begin nxt_y = y_pos - Y_W'(1); moved = 1'b1; end
            end
            ACT_DOWN: begin
                nxt_face = FACE_DOWN;
                if (!collision[1] && y_pos < Y_W'(Y_MAX)) begin nxt_y = y_pos + Y_W'(1); moved = 1'b1; end
            end
            ACT_LEFT: begin
                nxt_face = FACE_LEFT;
                if (!collision[2] && x_pos > X_W'(X_MIN)) begin nxt_x = x_pos - X_W'(1); moved = 1'b1; end
            end
            ACT_RIGHT: begin
                nxt_face = FACE_RIGHT;
                if (!collision[3] && x_pos < X_W'(X_MAX)) begin nxt_x = x_pos + X_W'(1); moved = 1'b1; end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_pos <= X_W'(X_INIT); y_pos <= Y_W'(Y_INIT);
            facing <= FACE_DOWN; action <= ACT_NONE; spd_cnt <= '0;
        end else if (init) begin
            x_pos <= X_W'(X_INIT); y_pos <= Y_W'(Y_INIT);
            facing <= FACE_DOWN; action <= ACT_NONE; spd_cnt <= '0;
        end else if (accept_reg) begin
            action <= nxt_action;
        end else if (accept_apply) begin
            spd_cnt <= (spd_cnt == SW'(SPEED_DIV-1)) ? '0 : spd_cnt + SW'(1);
            if (step) begin
                x_pos <= nxt_x; y_pos <= nxt_y; facing <= nxt_face;
            end
        end
    end

`ifdef WALK_ANIM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              frame <= 1'b0;
        else if (init)           frame <= 1'b0;
        else if (step && moved)  frame <= ~frame;
    end
`else
    assign frame = 1'b0;
`endif

    // Sheet origin, screen origin and extent of the sprite selected right now.
    always_comb begin
        g_ox       = ADDR_W'(facing) << SPR_W_SH;
        g_oy       = frame ? ADDR_W'(3*SPR_H) : '0;
        g_bx       = x_pos;
        g_by       = y_pos;
        g_col_last = CW'(SPR_W-1);
        g_row_last = RW'(SPR_H-1);
        if (action == ACT_ATTACK) begin
            case (facing)
                FACE_DOWN: begin
                    g_ox = '0; g_oy = ADDR_W'(SPR_H); g_row_last = RW'(2*SPR_H-1);
                end
                FACE_UP: begin
                    g_ox = ADDR_W'(SPR_W); g_oy = ADDR_W'(SPR_H); g_row_last = RW'(2*SPR_H-1);
                    g_by = y_pos - Y_W'(SPR_H);
                end
                FACE_LEFT: begin
                    g_ox = ADDR_W'(2*SPR_W); g_oy = ADDR_W'(SPR_H); g_col_last = CW'(2*SPR_W-1);
                    g_bx = x_pos - X_W'(SPR_W);
                end
                default: begin
                    g_ox = ADDR_W'(2*SPR_W); g_oy = ADDR_W'(2*SPR_H); g_col_last = CW'(2*SPR_W-1);
                end
            endcase
        end
    end

    assign a_last = (col == col_last) && (row == row_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE; col <= '0; row <= '0; col_last <= '0; row_last <= '0;
            org_x <= '0; org_y <= '0; base_x <= '0; base_y <= '0;
            pix_valid <= 1'b0; pix_last <= 1'b0; x_draw <= '0; y_draw <= '0;
        end else if (init) begin
            state <= ST_IDLE; pix_valid <= 1'b0; pix_last <= 1'b0;
        end else begin
            pix_valid <= (state == ST_SCAN);
            pix_last  <= (state == ST_SCAN) && a_last;
            if (state == ST_SCAN) begin
                x_draw <= base_x + X_W'(col);
                y_draw <= base_y + Y_W'(row);
            end
            case (state)
                ST_IDLE: if (draw_start && !busy) begin
                    org_x <= g_ox; org_y <= g_oy; base_x <= g_bx; base_y <= g_by;
                    col_last <= g_col_last; row_last <= g_row_last;
                    col <= '0; row <= '0; state <= ST_SCAN;
                end
                default: begin
                    if (a_last)                state <= ST_IDLE;
                    else if (col == col_last)  begin col <= '0; row <= row + RW'(1); end
                    else                       col <= col + CW'(1);
                end
            endcase
        end
    end

    always_comb begin
        rom_addr = '0;
        if (state == ST_SCAN)
            rom_addr = ((org_y + ADDR_W'(row)) << SHEET_SH) + org_x + ADDR_W'(col);
    end

    assign colour    = pix_valid ? rom_q : '0;
    assign vga_write = pix_valid && (rom_q != TRANSP);
    assign draw_done = pix_valid && pix_last;
endmodule
